// File: rtl/acc_arbiter_pkg.sv
// Shared definitions for the accumulator responder: sizes, operation
// encoding, the bundled request struct and the accumulator update rule.
package acc_arbiter_pkg;

  localparam int N_CORE = 4;
  localparam int N_ACC  = 2;

  typedef enum logic {
    ACC_SET = 1'b0,
    ACC_ADD = 1'b1
  } acc_op_t;

  typedef struct packed {
    logic        valid;
    acc_op_t     op;
    logic [31:0] data;
  } acc_req_t;

  // ADD wraps modulo 2^32; no carry or overflow is reported.
  function automatic logic [31:0] acc_apply(acc_op_t op, logic [31:0] cur, logic [31:0] operand);
    if (op == ACC_ADD) begin
      return cur + operand;
    end
    return operand;
  endfunction

endpackage

// File: rtl/acc_arbiter_rr_arbiter.sv
// Round-robin arbiter: scans from the pointer upward (mod N), grants the
// first requester one-hot, and moves the pointer just past the winner.
module rr_arbiter #(
  parameter  int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         any
);

  logic [W-1:0] r_ptr;
  logic [N-1:0] w_grant;
  logic [W-1:0] w_idx;
  logic         w_any;
  logic [W-1:0] w_k;
  int unsigned  w_sum;

  // Pick the first requester at or after the pointer; nothing while in reset.
  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    w_any   = 1'b0;
    w_sum   = 0;
    w_k     = '0;
    for (int i = 0; i < N; i++) begin
      w_sum = int'(r_ptr) + i;
      if (w_sum >= N) begin
        w_sum = w_sum - N;
      end
      w_k = w_sum[W-1:0];
      if (!w_any && req[w_k]) begin
        w_any        = 1'b1;
        w_grant[w_k] = 1'b1;
        w_idx        = w_k;
      end
    end
    if (reset) begin
      w_grant = '0;
      w_idx   = '0;
      w_any   = 1'b0;
    end
  end

  // Pointer advances to the core after the winner; holds when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_any) begin
      if (w_idx == W'(N - 1)) begin
        r_ptr <= '0;
      end else begin
        r_ptr <= w_idx + W'(1);
      end
    end
  end

  assign grant     = w_grant;
  assign grant_idx = w_idx;
  assign any       = w_any;

endmodule

// File: rtl/acc_arbiter.sv
// Shared accumulators: one round-robin arbiter and one 32-bit register per
// accumulator; every core sees the same registered value.
module acc_arbiter #(
  parameter int N_CORE = acc_arbiter_pkg::N_CORE,
  parameter int N_ACC  = acc_arbiter_pkg::N_ACC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid [N_CORE][N_ACC],
  input  logic        req_op    [N_CORE][N_ACC],
  input  logic [31:0] req_data  [N_CORE][N_ACC],
  output logic        req_ready [N_CORE][N_ACC],
  output logic [31:0] acc_data  [N_CORE][N_ACC]
);

  import acc_arbiter_pkg::*;

  localparam int CW = (N_CORE > 1) ? $clog2(N_CORE) : 1;

  for (genvar a = 0; a < N_ACC; a++) begin : g_acc
    logic [N_CORE-1:0] w_req;
    logic [N_CORE-1:0] w_grant;
    logic [CW-1:0]     w_idx;
    logic              w_any;
    logic [31:0]       r_acc;

    for (genvar c = 0; c < N_CORE; c++) begin : g_core
      assign w_req[c]        = req_valid[c][a];
      assign req_ready[c][a] = w_grant[c];
      assign acc_data[c][a]  = r_acc;
    end

    rr_arbiter #(.N(N_CORE)) u_rr (
      .clk       (clk),
      .reset     (reset),
      .req       (w_req),
      .grant     (w_grant),
      .grant_idx (w_idx),
      .any       (w_any)
    );

    // Apply the winning core's operation; hold when no core is granted.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_acc <= '0;
      end else if (w_any) begin
        r_acc <= acc_apply(acc_op_t'(req_op[w_idx][a]), r_acc, req_data[w_idx][a]);
      end
    end
  end

endmodule

// File: tb/tb_acc_arbiter.sv
// Directed bench for acc_arbiter with a queue-based scoreboard.
module tb_acc_arbiter;

  localparam int NC = 4;
  localparam int NA = 2;

  logic        clk;
  logic        reset;
  logic        req_valid [NC][NA];
  logic        req_op    [NC][NA];
  logic [31:0] req_data  [NC][NA];
  logic        req_ready [NC][NA];
  logic [31:0] acc_data  [NC][NA];

  typedef struct {
    logic [7:0]  rdy;   // bit c*2+a
    logic [31:0] acc0;
    logic [31:0] acc1;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  acc_arbiter #(.N_CORE(NC), .N_ACC(NA)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_data  (req_data),
    .req_ready (req_ready),
    .acc_data  (acc_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expectation per cycle, compared at the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t        e;
      logic [7:0]  got;
      logic [31:0] want;
      e   = exp_q.pop_front();
      got = '0;
      for (int c = 0; c < NC; c++)
        for (int a = 0; a < NA; a++)
          got[c*2+a] = req_ready[c][a];
      checks++;
      if (got !== e.rdy) begin
        errors++;
        $display("FAIL %s ready got %h want %h", e.name, got, e.rdy);
      end
      for (int c = 0; c < NC; c++) begin
        for (int a = 0; a < NA; a++) begin
          want = (a == 0) ? e.acc0 : e.acc1;
          checks++;
          if (acc_data[c][a] !== want) begin
            errors++;
            $display("FAIL %s acc_data[%0d][%0d] got %h want %h", e.name, c, a, acc_data[c][a], want);
          end
        end
      end
    end
  end

  task automatic clear_all();
    for (int c = 0; c < NC; c++)
      for (int a = 0; a < NA; a++) begin
        req_valid[c][a] = 1'b0;
        req_op[c][a]    = 1'b0;
        req_data[c][a]  = 32'h0;
      end
  endtask

  task automatic set_req(input int c, input int a, input logic op, input logic [31:0] d);
    req_valid[c][a] = 1'b1;
    req_op[c][a]    = op;
    req_data[c][a]  = d;
  endtask

  // Push the expectation for the cycle just driven, then advance one cycle.
  task automatic step(input logic [7:0] rdy, input logic [31:0] a0, input logic [31:0] a1, input string nm);
    exp_t e;
    e.rdy  = rdy;
    e.acc0 = a0;
    e.acc1 = a1;
    e.name = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    for (int c = 0; c < NC; c++)
      for (int a = 0; a < NA; a++)
        set_req(c, a, 1'b1, 32'h1);
    @(posedge clk);
    #1;

    // Reset with every valid asserted
    step(8'h00, 32'h0, 32'h0, "rst_all_valid_a");
    step(8'h00, 32'h0, 32'h0, "rst_all_valid_b");
    reset = 1'b0;
    clear_all();
    step(8'h00, 32'h0, 32'h0, "idle");

    // Core 2 SET 5 then ADD 7 on acc0
    set_req(2, 0, 1'b0, 32'd5);
    step(8'h10, 32'd0, 32'd0, "set5");
    clear_all();
    set_req(2, 0, 1'b1, 32'd7);
    step(8'h10, 32'd5, 32'd0, "add7");
    clear_all();
    step(8'h00, 32'd12, 32'd0, "after_add7");

    // Wrap: SET all-ones then ADD 2 (pointer now at 3, core 0 is the only requester)
    set_req(0, 0, 1'b0, 32'hFFFF_FFFF);
    step(8'h01, 32'd12, 32'd0, "set_ffff");
    clear_all();
    set_req(0, 0, 1'b1, 32'd2);
    step(8'h01, 32'hFFFF_FFFF, 32'd0, "add2_wrap");
    clear_all();
    step(8'h00, 32'h1, 32'd0, "after_wrap");

    // Contention from reset: all four cores ADD 1 to acc0
    reset = 1'b1;
    step(8'h00, 32'h1, 32'd0, "rst2");
    reset = 1'b0;
    for (int c = 0; c < NC; c++) set_req(c, 0, 1'b1, 32'd1);
    step(8'h01, 32'd0, 32'd0, "rr_c0_a");
    step(8'h04, 32'd1, 32'd0, "rr_c1_a");
    step(8'h10, 32'd2, 32'd0, "rr_c2_a");
    step(8'h40, 32'd3, 32'd0, "rr_c3_a");
    step(8'h01, 32'd4, 32'd0, "rr_c0_b");
    step(8'h04, 32'd5, 32'd0, "rr_c1_b");
    step(8'h10, 32'd6, 32'd0, "rr_c2_b");
    step(8'h40, 32'd7, 32'd0, "rr_c3_b");
    clear_all();
    step(8'h00, 32'd8, 32'd0, "rr_total");

    // Independence: core 0 on both accumulators in one cycle
    reset = 1'b1;
    step(8'h00, 32'd8, 32'd0, "rst3");
    reset = 1'b0;
    step(8'h00, 32'd0, 32'd0, "post_rst3");
    set_req(0, 0, 1'b1, 32'd3);
    set_req(0, 1, 1'b1, 32'd4);
    step(8'h03, 32'd0, 32'd0, "indep_grant");
    clear_all();
    step(8'h00, 32'd3, 32'd4, "indep_vals");

    // Reset mid-stream: cores 1 and 3 contend on acc0
    set_req(1, 0, 1'b1, 32'd10);
    set_req(3, 0, 1'b1, 32'd100);
    step(8'h04, 32'd3, 32'd4, "mid_c1");
    reset = 1'b1;
    step(8'h00, 32'd13, 32'd4, "mid_rst_a");
    step(8'h00, 32'd0, 32'd0, "mid_rst_b");
    reset = 1'b0;
    step(8'h04, 32'd0, 32'd0, "post_rst_c1");
    step(8'h40, 32'd10, 32'd0, "post_rst_c3");
    clear_all();
    step(8'h00, 32'd110, 32'd0, "post_rst_final");

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_arbiter.md
# acc_arbiter

Shared-accumulator responder that serves the `acc_req` / `acc_data` fabric connecting all cores. Each of `N_ACC` accumulators takes at most one request per cycle, granted round-robin among the `N_CORE` requesting cores. Each accumulator's registered value is broadcast back to every core. It sits in `top` beside the parent and child cores and is the only writer of `acc_data`.

## Interface
Parameters:
- `N_CORE`, default `N_CORE` from the common header: number of requesting cores.
- `N_ACC`, default `N_ACC` from the common header: number of accumulators.

Ports:
- `clk`, in, 1: single system clock.
- `reset`, in, 1: synchronous, active-high reset.
- `req_valid[N_CORE][N_ACC]`, in, 1: core *c* requests accumulator *a*.
- `req_op[N_CORE][N_ACC]`, in, 1: operation, `ACC_SET`=0 or `ACC_ADD`=1.
- `req_data[N_CORE][N_ACC]`, in, 32: operand.
- `req_ready[N_CORE][N_ACC]`, out, 1: grant. A request is accepted in a cycle where valid and ready are both 1.
- `acc_data[N_CORE][N_ACC]`, out, 32: registered accumulator value, identical for all *c*.

## Operation
- Each accumulator *a* has an independent arbiter, a 32-bit value register `acc[a]` and a round-robin pointer `ptr[a]` that is `$clog2(N_CORE)` bits wide.
- Grant: scan cores `ptr[a], ptr[a]+1, …` modulo `N_CORE`. The first core with `req_valid` set gets `req_ready`=1; every other core's ready for *a* is 0.
- `req_ready` is combinational from `req_valid` and `ptr`. It must not depend on `req_op` or `req_data`.
- On an accepted request from core *g*:
  - `ACC_SET`: `acc[a] <= req_data`.
  - `ACC_ADD`: `acc[a] <= acc[a] + req_data`, 32-bit two's-complement with wrap-around and no carry or overflow flag.
  - `ptr[a] <= (g+1) mod N_CORE`.
- If no core requests *a*, `acc[a]` and `ptr[a]` hold.
- Cores are independent across accumulators. One core may be granted on several accumulators in the same cycle.
- `acc_data[c][a] = acc[a]` for every *c*, driven from the register with no combinational path from the request inputs.
- Reset:
  - `acc[a]`=0 and `ptr[a]`=0.
  - `req_ready` is forced to 0 while `reset` is high. Requests presented during reset are not accepted.
  - Reset asserted mid-stream discards any in-progress contention. The first grant after reset goes to the lowest-numbered requesting core.

## Timing
- Grant is in the same cycle as the request: 0-cycle handshake.
- Update latency is 1 cycle. A request accepted in cycle *t* is visible on `acc_data` in cycle *t+1*.
- Back-to-back accepts on the same accumulator chain correctly. An ADD in *t+1* sees the result of the accept in *t*.
- Throughput is one accepted request per accumulator per cycle.
- Fairness: a continuously requesting core is granted within `N_CORE` cycles.
- A core must hold valid, op and data stable until accepted. The block does not check this.
- Reset values of outputs: `req_ready`=0 and `acc_data`=0.

## Structure
- The common package / `common.vh` holds `N_CORE`, `N_ACC`, the `acc_op_t` enum (`ACC_SET`, `ACC_ADD`), and a bundled `acc_req_t` struct (valid, op, data) for `req_if`.
- One natural sub-module is `rr_arbiter`, parameterized by `N`. Ports: `clk`, `reset`, `req[N]`, `grant[N]` (one-hot), `grant_idx`, `any`; the pointer register lives inside it. `acc_arbiter` instantiates it once per accumulator in a generate loop.
- A `top` update replaces the loose `acc_data` with this block's output.

## Test plan
Defaults `N_CORE`=4, `N_ACC`=2 unless stated.
- Reset → `acc_data` is 0 on all ports and `req_ready` is 0 while reset is high, even with all valids set.
- Single SET then ADD: core 2 sets acc[0]=5, then core 2 adds 7 → `acc_data[*][0]` is 5 in the cycle after the set and 12 in the cycle after the add. acc[1] stays 0.
- Wrap: SET 0xFFFFFFFF, then ADD 2 → 0x00000001.
- Contention: all 4 cores hold ADD 1 to acc[0] from reset → grant order is 0,1,2,3,0. After 8 cycles acc[0]=8, and exactly one ready is set per cycle.
- Independence: core 0 adds 3 to acc[0] and core 0 adds 4 to acc[1] in the same cycle → both granted; next cycle the values are 3 and 4.
- Reset mid-stream: cores 1 and 3 contend, and reset is applied after core 1 is granted → after reset acc=0 and core 1 is granted first again; no updates occur during reset.
